// File: rtl/xadc_drp_responder_pkg.sv
// Shared constants and types for the XADC DRP responder: register map,
// conversion order and the DRP handshake state encoding.
package xadc_pkg;

    localparam logic [6:0] ADDR_AUX6  = 7'h16;
    localparam logic [6:0] ADDR_AUX7  = 7'h17;
    localparam logic [6:0] ADDR_AUX14 = 7'h1E;
    localparam logic [6:0] ADDR_AUX15 = 7'h1F;
    localparam logic [6:0] ADDR_CFG0  = 7'h40;
    localparam logic [6:0] ADDR_CFG1  = 7'h41;
    localparam logic [6:0] ADDR_CFG2  = 7'h42;

    localparam int NUM_CHANNELS = 4;

    // Entry 0 is the first channel converted after reset.
    localparam logic [NUM_CHANNELS-1:0][6:0] CHANNEL_ORDER =
        {ADDR_AUX15, ADDR_AUX14, ADDR_AUX7, ADDR_AUX6};

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } drpState_e;

    function automatic logic isCfgAddr(input logic [6:0] addr);
        return (addr >= ADDR_CFG0) && (addr <= ADDR_CFG2);
    endfunction

endpackage

// File: rtl/xadc_drp_responder_if.sv
// DRP bus between a requester (master) and the XADC responder (slave);
// signal names follow the XADC primitive so existing reader logic plugs in.
interface xadc_drp_responder_if;

    logic [6:0]  daddr_in;
    logic        den_in;
    logic        dwe_in;
    logic [15:0] di_in;
    logic [15:0] do_out;
    logic        drdy_out;

    modport master (
        output daddr_in,
        output den_in,
        output dwe_in,
        output di_in,
        input  do_out,
        input  drdy_out
    );

    modport slave (
        input  daddr_in,
        input  den_in,
        input  dwe_in,
        input  di_in,
        output do_out,
        output drdy_out
    );

endinterface

// File: rtl/xadc_drp_responder_drp_port.sv
// DRP handshake: accepts one access at a time, answers after a fixed latency
// with a single-cycle drdy pulse, and flags requests that arrive while busy.
module drp_port
    import xadc_pkg::*;
#(
    parameter int DRDY_LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rstN_i,
    input  logic        den_i,
    input  logic        dwe_i,
    input  logic [15:0] rdData_i,
    output logic        wrEn_o,
    output logic        drdy_o,
    output logic [15:0] do_o,
    output logic        protoErr_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(DRDY_LATENCY >= 2 ? DRDY_LATENCY - 2 : 0);

    drpState_e   state_q, state_d;
    logic [3:0]  waitCnt_q, waitCnt_d;
    logic [15:0] data_q, data_d;
    logic [15:0] do_q, do_d;
    logic        protoErr_q, protoErr_d;
    logic [15:0] acceptData;

    // Writes answer with zero; reads capture the value visible in the den cycle.
    assign acceptData = dwe_i ? 16'h0000 : rdData_i;

    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        data_d     = data_q;
        do_d       = do_q;
        protoErr_d = protoErr_q;
        wrEn_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (den_i) begin
                    wrEn_o    = dwe_i;
                    data_d    = acceptData;
                    waitCnt_d = WAIT_LOAD;
                    if (DRDY_LATENCY == 1) begin
                        state_d = RESP;
                        do_d    = acceptData;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (den_i) protoErr_d = 1'b1;
                if (waitCnt_q == 4'd0) begin
                    state_d = RESP;
                    do_d    = data_q;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            RESP: begin
                if (den_i) protoErr_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstN_i) begin
            state_q    <= IDLE;
            waitCnt_q  <= 4'd0;
            data_q     <= 16'h0000;
            do_q       <= 16'h0000;
            protoErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            data_q     <= data_d;
            do_q       <= do_d;
            protoErr_q <= protoErr_d;
        end
    end

    assign drdy_o     = (state_q == RESP);
    assign do_o       = do_q;
    assign protoErr_o = protoErr_q;

endmodule

// File: rtl/xadc_drp_responder.sv
// Behavioural XADC stand-in: round-robin sequencer over aux 6/7/14/15,
// status/config register file, and a DRP port answering reads and writes.
module xadc_drp_responder
    import xadc_pkg::*;
#(
    parameter int CONV_CYCLES  = 26,
    parameter int DRDY_LATENCY = 4
) (
    input  logic                 CLK100MHZ,
    input  logic                 clr_n,
    input  logic [11:0]          aux6_val,
    input  logic [11:0]          aux7_val,
    input  logic [11:0]          aux14_val,
    input  logic [11:0]          aux15_val,
    xadc_drp_responder_if.slave  drp,
    output logic                 eoc_out,
    output logic [4:0]           channel_out,
    output logic                 busy_out,
    output logic                 proto_err
);

    localparam int CNT_W = $clog2(CONV_CYCLES);

    logic [CNT_W-1:0]               convCnt_q, convCnt_d;
    logic [1:0]                     idx_q, idx_d;
    logic                           eoc_q, eoc_d;
    logic [4:0]                     channel_q, channel_d;
    logic                           started_q;
    logic [NUM_CHANNELS-1:0][15:0]  status_q, status_d;
    logic [2:0][15:0]               cfg_q, cfg_d;

    logic        frozen;
    logic        terminal;
    logic [11:0] sample;
    logic [15:0] rdData;
    logic        wrEn;

    assign frozen   = cfg_q[1][0];
    assign terminal = (convCnt_q == CNT_W'(CONV_CYCLES - 1));

    always_comb begin
        sample = aux6_val;
        case (idx_q)
            2'd0:    sample = aux6_val;
            2'd1:    sample = aux7_val;
            2'd2:    sample = aux14_val;
            default: sample = aux15_val;
        endcase
    end

    // A frozen sequencer holds its counter and index and never completes.
    always_comb begin
        convCnt_d = convCnt_q;
        idx_d     = idx_q;
        eoc_d     = 1'b0;
        channel_d = channel_q;
        status_d  = status_q;
        if (!frozen) begin
            if (terminal) begin
                convCnt_d       = '0;
                idx_d           = idx_q + 2'd1;
                eoc_d           = 1'b1;
                channel_d       = CHANNEL_ORDER[idx_q][4:0];
                status_d[idx_q] = {sample, 4'h0};
            end else begin
                convCnt_d = convCnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cfg_d = cfg_q;
        if (wrEn && isCfgAddr(drp.daddr_in)) begin
            cfg_d[drp.daddr_in[1:0]] = drp.di_in;
        end
    end

    always_comb begin
        rdData = 16'h0000;
        case (drp.daddr_in)
            ADDR_AUX6:  rdData = status_q[0];
            ADDR_AUX7:  rdData = status_q[1];
            ADDR_AUX14: rdData = status_q[2];
            ADDR_AUX15: rdData = status_q[3];
            ADDR_CFG0:  rdData = cfg_q[0];
            ADDR_CFG1:  rdData = cfg_q[1];
            ADDR_CFG2:  rdData = cfg_q[2];
            default:    rdData = 16'h0000;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!clr_n) begin
            convCnt_q <= '0;
            idx_q     <= 2'd0;
            eoc_q     <= 1'b0;
            channel_q <= ADDR_AUX6[4:0];
            started_q <= 1'b0;
            status_q  <= '0;
            cfg_q     <= '0;
        end else begin
            convCnt_q <= convCnt_d;
            idx_q     <= idx_d;
            eoc_q     <= eoc_d;
            channel_q <= channel_d;
            started_q <= 1'b1;
            status_q  <= status_d;
            cfg_q     <= cfg_d;
        end
    end

    drp_port #(
        .DRDY_LATENCY (DRDY_LATENCY)
    ) u_drpPort (
        .clk_i      (CLK100MHZ),
        .rstN_i     (clr_n),
        .den_i      (drp.den_in),
        .dwe_i      (drp.dwe_in),
        .rdData_i   (rdData),
        .wrEn_o     (wrEn),
        .drdy_o     (drp.drdy_out),
        .do_o       (drp.do_out),
        .protoErr_o (proto_err)
    );

    assign eoc_out     = eoc_q;
    assign channel_out = channel_q;
    assign busy_out    = started_q & ~eoc_q & ~frozen;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Bench for xadc_drp_responder: directed scenarios and a DRP transaction table
// checked against constants, plus random traffic checked against a cycle model.
module tb_xadc_drp_responder;

    localparam int CONV = 26;
    localparam int LAT  = 4;
    localparam logic [6:0] CHAN_ADDR [4] = '{7'h16, 7'h17, 7'h1E, 7'h1F};

    logic        clk = 1'b0;
    logic        clrN;
    logic [11:0] aux6Val, aux7Val, aux14Val, aux15Val;
    logic        eocOut;
    logic [4:0]  channelOut;
    logic        busyOut;
    logic        protoErr;

    xadc_drp_responder_if drpIf ();

    xadc_drp_responder #(
        .CONV_CYCLES  (CONV),
        .DRDY_LATENCY (LAT)
    ) dut (
        .CLK100MHZ   (clk),
        .clr_n       (clrN),
        .aux6_val    (aux6Val),
        .aux7_val    (aux7Val),
        .aux14_val   (aux14Val),
        .aux15_val   (aux15Val),
        .drp         (drpIf),
        .eoc_out     (eocOut),
        .channel_out (channelOut),
        .busy_out    (busyOut),
        .proto_err   (protoErr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int drdySeen = 0;

    // Reference model state: edge counts and plain arithmetic on them.
    int          edgeNo = 0;
    int          busyUntil = 0;
    int          respEdge = -1;
    int          activeCycles = 0;
    logic [15:0] respData = 16'h0;
    logic [15:0] mDo = 16'h0;
    logic        mDrdy = 1'b0, mEoc = 1'b0, mBusy = 1'b0, mProto = 1'b0, mStarted = 1'b0;
    logic [4:0]  mChan = 5'h16;
    logic [15:0] mStatus [4];
    logic [15:0] mCfg [3];

    typedef struct {
        string       name;
        logic [6:0]  addr;
        logic        wr;
        logic [15:0] di;
        logic [15:0] expDo;
    } drpVec_t;

    drpVec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] auxOf(input int n);
        case (n)
            0:       return aux6Val;
            1:       return aux7Val;
            2:       return aux14Val;
            default: return aux15Val;
        endcase
    endfunction

    function automatic logic [15:0] readModel(input logic [6:0] addr);
        for (int i = 0; i < 4; i++) if (addr == CHAN_ADDR[i]) return mStatus[i];
        if (addr >= 7'h40 && addr <= 7'h42) return mCfg[int'(addr) - 64];
        return 16'h0000;
    endfunction

    task automatic modelEdge();
        logic frozenNow;
        int   n;
        edgeNo++;
        if (!clrN) begin
            busyUntil    = edgeNo;
            respEdge     = -1;
            activeCycles = 0;
            mDo = 16'h0; mDrdy = 1'b0; mEoc = 1'b0; mProto = 1'b0; mStarted = 1'b0;
            mChan = 5'h16;
            for (int i = 0; i < 4; i++) mStatus[i] = 16'h0;
            for (int i = 0; i < 3; i++) mCfg[i] = 16'h0;
        end else begin
            frozenNow = mCfg[1][0];
            mDrdy = 1'b0;
            if (drpIf.den_in) begin
                if (edgeNo > busyUntil) begin
                    respEdge  = edgeNo + LAT - 1;
                    busyUntil = edgeNo + LAT;
                    respData  = drpIf.dwe_in ? 16'h0 : readModel(drpIf.daddr_in);
                    if (drpIf.dwe_in && drpIf.daddr_in >= 7'h40 && drpIf.daddr_in <= 7'h42)
                        mCfg[int'(drpIf.daddr_in) - 64] = drpIf.di_in;
                end else begin
                    mProto = 1'b1;
                end
            end
            if (edgeNo == respEdge) begin
                mDrdy = 1'b1;
                mDo   = respData;
            end
            mEoc = 1'b0;
            if (!frozenNow) begin
                activeCycles++;
                if (activeCycles % CONV == 0) begin
                    n = (activeCycles / CONV - 1) % 4;
                    mEoc       = 1'b1;
                    mChan      = CHAN_ADDR[n][4:0];
                    mStatus[n] = {auxOf(n), 4'h0};
                end
            end
            mStarted = 1'b1;
        end
        mBusy = mStarted && !mEoc && !mCfg[1][0];
    endtask

    task automatic checkOutput();
        check("drdy_out",    32'(drpIf.drdy_out), 32'(mDrdy));
        check("do_out",      32'(drpIf.do_out),   32'(mDo));
        check("eoc_out",     32'(eocOut),         32'(mEoc));
        check("channel_out", 32'(channelOut),     32'(mChan));
        check("busy_out",    32'(busyOut),        32'(mBusy));
        check("proto_err",   32'(protoErr),       32'(mProto));
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
        if (drpIf.drdy_out === 1'b1) drdySeen++;
    endtask

    task automatic applyStimulus(input logic den, input logic dwe, input logic [6:0] addr,
                                 input logic [15:0] di);
        drpIf.den_in   = den;
        drpIf.dwe_in   = dwe;
        drpIf.daddr_in = addr;
        drpIf.di_in    = di;
        step();
        drpIf.den_in = 1'b0;
        drpIf.dwe_in = 1'b0;
    endtask

    task automatic drpTransaction(input string name, input logic [6:0] addr, input logic wr,
                                  input logic [15:0] di, input logic [15:0] expDo);
        int lat;
        applyStimulus(1'b1, wr, addr, di);
        lat = 1;
        while (drpIf.drdy_out !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(LAT));
        check({name, " data"}, 32'(drpIf.do_out), 32'(expDo));
        step();
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, " do_out"},      32'(drpIf.do_out),   32'h0);
        check({tag, " drdy_out"},    32'(drpIf.drdy_out), 32'h0);
        check({tag, " eoc_out"},     32'(eocOut),         32'h0);
        check({tag, " channel_out"}, 32'(channelOut),     32'h16);
        check({tag, " busy_out"},    32'(busyOut),        32'h0);
        check({tag, " proto_err"},   32'(protoErr),       32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k, lastEoc, eocCount;
        int sel;
        logic [6:0] addr;
        logic wr;

        vecs.push_back('{"freeze write 41",  7'h41, 1'b1, 16'h0001, 16'h0000});
        vecs.push_back('{"read 41",          7'h41, 1'b0, 16'h0000, 16'h0001});
        vecs.push_back('{"read 16",          7'h16, 1'b0, 16'h0000, 16'h8000});
        vecs.push_back('{"read 17",          7'h17, 1'b0, 16'h0000, 16'h1230});
        vecs.push_back('{"read 1E",          7'h1E, 1'b0, 16'h0000, 16'hABC0});
        vecs.push_back('{"read 1F",          7'h1F, 1'b0, 16'h0000, 16'hFFF0});
        vecs.push_back('{"write 40",         7'h40, 1'b1, 16'hBEEF, 16'h0000});
        vecs.push_back('{"read 40",          7'h40, 1'b0, 16'h0000, 16'hBEEF});
        vecs.push_back('{"write 42",         7'h42, 1'b1, 16'h1234, 16'h0000});
        vecs.push_back('{"read 42",          7'h42, 1'b0, 16'h0000, 16'h1234});
        vecs.push_back('{"read 00",          7'h00, 1'b0, 16'h0000, 16'h0000});
        vecs.push_back('{"write 16 dropped", 7'h16, 1'b1, 16'h5555, 16'h0000});
        vecs.push_back('{"read 16 after",    7'h16, 1'b0, 16'h0000, 16'h8000});
        vecs.push_back('{"read 43",          7'h43, 1'b0, 16'h0000, 16'h0000});
        vecs.push_back('{"read 7F",          7'h7F, 1'b0, 16'h0000, 16'h0000});

        clrN = 1'b0;
        aux6Val = 12'h800; aux7Val = 12'h123; aux14Val = 12'hABC; aux15Val = 12'hFFF;
        drpIf.den_in = 1'b0; drpIf.dwe_in = 1'b0; drpIf.daddr_in = 7'h0; drpIf.di_in = 16'h0;

        // First conversion after reset, then a read tied to its eoc pulse.
        step(); step();
        checkResetOutputs("reset");
        clrN = 1'b1;
        k = 0;
        do begin step(); k++; end while (eocOut !== 1'b1 && k < CONV + 10);
        check("first eoc edges after release", 32'(k), 32'(CONV));
        check("first eoc channel", 32'(channelOut), 32'h16);
        lastEoc = edgeNo;
        drpTransaction("eoc-tied read 16", 7'h16, 1'b0, 16'h0, 16'h8000);

        // Eight more conversions: fixed spacing and round-robin order.
        for (int i = 0; i < 8; i++) begin
            k = 0;
            do begin step(); k++; end while (eocOut !== 1'b1 && k < CONV + 5);
            check("eoc spacing", 32'(edgeNo - lastEoc), 32'(CONV));
            check("eoc channel", 32'(channelOut), 32'(CHAN_ADDR[(i + 1) % 4][4:0]));
            lastEoc = edgeNo;
        end

        for (int i = 0; i < vecs.size(); i++)
            drpTransaction(vecs[i].name, vecs[i].addr, vecs[i].wr, vecs[i].di, vecs[i].expDo);

        eocCount = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (eocOut === 1'b1) eocCount++;
        end
        check("eoc while frozen", 32'(eocCount), 32'h0);
        check("busy while frozen", 32'(busyOut), 32'h0);
        drpTransaction("unfreeze write 41", 7'h41, 1'b1, 16'h0000, 16'h0000);
        k = 0;
        do begin step(); k++; end while (eocOut !== 1'b1 && k < CONV + 5);
        check("eoc resumes", 32'(eocOut), 32'h1);

        // Overlapping request: flagged, ignored, one response only.
        drdySeen = 0;
        applyStimulus(1'b1, 1'b0, 7'h16, 16'h0);
        applyStimulus(1'b0, 1'b0, 7'h00, 16'h0);
        applyStimulus(1'b1, 1'b0, 7'h17, 16'h0);
        for (int i = 0; i < 20; i++) step();
        check("overlap drdy count", 32'(drdySeen), 32'h1);
        check("overlap data", 32'(drpIf.do_out), 32'h8000);
        check("proto_err set", 32'(protoErr), 32'h1);
        for (int i = 0; i < 10; i++) step();
        check("proto_err sticky", 32'(protoErr), 32'h1);

        // Reset while the access is in flight.
        applyStimulus(1'b1, 1'b0, 7'h16, 16'h0);
        step();
        clrN = 1'b0;
        step();
        checkResetOutputs("mid-access reset");
        clrN = 1'b1;
        drdySeen = 0;
        for (int i = 0; i < LAT + 4; i++) step();
        check("no drdy after reset", 32'(drdySeen), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            aux6Val  = 12'($urandom);
            aux7Val  = 12'($urandom);
            aux14Val = 12'($urandom);
            aux15Val = 12'($urandom);
            clrN = ($urandom_range(0, 199) != 0);
            sel  = int'($urandom_range(0, 8));
            if (sel < 4)      addr = CHAN_ADDR[sel];
            else if (sel < 7) addr = 7'(7'h40 + sel - 4);
            else              addr = 7'($urandom);
            wr = 1'($urandom);
            applyStimulus(($urandom_range(0, 4) == 0), wr, addr, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
